// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the pipelined ALU.
// The 6-bit alufn layout is {group[3:0], op[1:0]}.
package alu_pkg;

    localparam logic [3:0] GRP_ARITH = 4'b0000;
    localparam logic [3:0] GRP_LOGIC = 4'b0001;
    localparam logic [3:0] GRP_SHIFT = 4'b0010;

    localparam logic [5:0] ALU_ADD = {GRP_ARITH, 2'b00};
    localparam logic [5:0] ALU_SUB = {GRP_ARITH, 2'b01};
    localparam logic [5:0] ALU_MUL = {GRP_ARITH, 2'b10};
    localparam logic [5:0] ALU_AND = {GRP_LOGIC, 2'b00};
    localparam logic [5:0] ALU_OR  = {GRP_LOGIC, 2'b01};
    localparam logic [5:0] ALU_XOR = {GRP_LOGIC, 2'b10};
    localparam logic [5:0] ALU_NOR = {GRP_LOGIC, 2'b11};
    localparam logic [5:0] ALU_SLL = {GRP_SHIFT, 2'b00};
    localparam logic [5:0] ALU_SRL = {GRP_SHIFT, 2'b01};
    localparam logic [5:0] ALU_SRA = {GRP_SHIFT, 2'b10};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Arithmetic and shift groups each leave their fourth slot unused.
    function automatic logic is_legal(input logic [5:0] fn);
        case (fn[5:2])
            GRP_ARITH: return fn[1:0] != 2'b11;
            GRP_LOGIC: return 1'b1;
            GRP_SHIFT: return fn[1:0] != 2'b11;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle.
// done is raised during the final step, with product already including it.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;
    logic               running;

    // mcand is pre-shifted and mplier consumed LSB-first, so bit[count]
    // of the original multiplier is always mplier[0].
    always_comb begin
        addend = mplier[0] ? mcand : '0;
    end

    assign product = acc + addend;
    assign busy    = running;
    assign done    = running && (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            acc     <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CNT_ONE;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU with registered results; MUL is delegated to seq_multiplier.
// Non-MUL ops complete in one cycle and can stream back-to-back from DONE.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       alufn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] otp,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             illegal
);

    alu_state_e state, state_next;

    logic               accept;
    logic               is_mul_op;
    logic [WIDTH-1:0]   res_otp;
    logic               res_ovf;
    logic               res_carry;
    logic [WIDTH:0]     wide;
    logic [SHW-1:0]     shamt;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign accept    = in_valid && in_ready;
    assign is_mul_op = (alufn == ALU_MUL);
    assign shamt     = b[SHW-1:0];

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul_op),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; illegal opcodes fall through to an all-zero result.
    always_comb begin
        res_otp   = '0;
        res_ovf   = 1'b0;
        res_carry = 1'b0;
        wide      = '0;
        case (alufn)
            ALU_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                res_otp   = wide[WIDTH-1:0];
                res_carry = wide[WIDTH];
                res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res_otp[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                wide      = {1'b0, a} - {1'b0, b};
                res_otp   = wide[WIDTH-1:0];
                res_carry = ~wide[WIDTH];
                res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res_otp[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: res_otp = a & b;
            ALU_OR:  res_otp = a | b;
            ALU_XOR: res_otp = a ^ b;
            ALU_NOR: res_otp = ~(a | b);
            ALU_SLL: res_otp = a << shamt;
            ALU_SRL: res_otp = a >> shamt;
            ALU_SRA: res_otp = $unsigned($signed(a) >>> shamt);
            default: res_otp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A MUL-state exit without done only happens if the engine was lost.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = is_mul_op ? MUL : DONE;
                end else if (state == DONE && !out_ready) begin
                    state_next = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = DONE;
                end else if (!mul_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            otp      <= '0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept && !is_mul_op) begin
            otp      <= res_otp;
            overflow <= res_ovf;
            carry    <= res_carry;
            illegal  <= !is_legal(alufn);
        end else if (mul_done) begin
            otp      <= mul_product[WIDTH-1:0];
            overflow <= |mul_product[2*WIDTH-1:WIDTH];
            carry    <= 1'b0;
            illegal  <= 1'b0;
        end
    end

    assign zero = (otp == '0);

endmodule
